vector_pair_loader: RTL and testbench
=====================================

Name: vector_pair_loader

Overview:
- Upstream feeder for the combinational 4-element scalar-product stage.
- Accepts one (x, y) 32-bit element pair per cycle over a valid/ready handshake.
- Packs the pairs into the two SIZE-bit operand buses IX/IY, with element k at bits [k*SIZE_INT +: SIZE_INT] (element 0 at the LSBs).
- Holds the completed pair stable under out_valid until the consumer takes it.

Parameters:
- SIZE_ARRAY, 4, number of elements per vector.
- SIZE_INT, 32, element width in bits.
- SIZE, SIZE_ARRAY*SIZE_INT, packed bus width (derived; not overridden).
- CW, $clog2(SIZE_ARRAY+1), width of out_count (derived; 3 at default).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  element pair present on in_x/in_y.
- in_ready  out  1  loader can accept an element this cycle.
- in_x  in  SIZE_INT  X element.
- in_y  in  SIZE_INT  Y element.
- in_last  in  1  final element of a short vector; qualified by in_valid.
- out_valid  out  1  IX/IY hold a complete vector pair.
- out_ready  in  1  consumer accepts the vector this cycle.
- IX  out  SIZE  packed X vector.
- IY  out  SIZE  packed Y vector.
- out_count  out  CW  number of real (non-padded) elements in the vector, 1..SIZE_ARRAY.

Behaviour:
- Reset (rst_n low, async):
  - State=FILL, write index idx=0.
  - IX=0, IY=0, out_valid=0, out_count=0, in_ready=1.
  - Any partial vector is discarded; no output is produced for it.
- States: FILL, HOLD. in_ready = (state==FILL); out_valid = (state==HOLD). Both are decoded from registered state only, with no combinational path from inputs.
- FILL:
  - On in_valid & in_ready, write in_x to IX slot idx and in_y to IY slot idx, then idx++.
  - in_last and in_x/in_y are ignored when in_valid=0.
- Vector close: triggered by an accept with idx==SIZE_ARRAY-1 or in_last=1. On that same edge:
  - Zero all slots above idx in IX and IY.
  - Set out_count=idx+1.
  - Move to HOLD (out_valid=1 from the next cycle).
  - in_last on the last slot (idx==SIZE_ARRAY-1) behaves exactly like a normal full close.
- HOLD:
  - in_ready=0. IX, IY and out_count stay bit-stable for as long as out_ready=0.
  - On out_valid & out_ready: next state FILL, idx=0, out_count unchanged.
  - IX/IY keep their old contents until overwritten slot by slot.
- Output validity: during FILL, IX/IY are partially updated and undefined for the consumer. The consumer uses them only while out_valid=1.
- Latency: out_valid rises exactly 1 cycle after the closing accept edge.
- Throughput: with continuous in_valid and out_ready=1, a full vector takes SIZE_ARRAY+1 cycles. The HOLD cycle is one mandatory bubble; there is no FILL/HOLD overlap.
- Data handling:
  - Elements pass through unmodified: no sign extension, no arithmetic.
  - Zero padding guarantees padded slots contribute 0 to the downstream sum of products.
- in_valid held high in HOLD: no acceptance, data on in_x/in_y is not consumed, and the same pair is accepted on the first FILL cycle.
- idx never exceeds SIZE_ARRAY-1; overflow is impossible by construction.

Test Plan:
1. Reset mid-fill: accept x=7,8 then pull rst_n low for 1 cycle -> immediately IX=IY=0, out_valid=0, in_ready=1. Next 4 accepts build a fresh vector with no trace of 7/8.
2. Full vector:
   - Stimulus: x=1,2,3,4 and y=5,6,7,8 on consecutive cycles, out_ready=1.
   - out_valid high for exactly 1 cycle, one cycle after the 4th accept.
   - IX=0x00000004_00000003_00000002_00000001, IY=0x00000008_00000007_00000006_00000005, out_count=4.
   - Downstream result=70. Next vector accepted 5 cycles after the first accept.
3. Short vector: x=3,4 and y=10,20, in_last on the 2nd element -> IX[127:64]=0, IY[127:64]=0, out_count=2, downstream result=110.
4. Backpressure: complete a vector, hold out_ready=0 for 5 cycles with in_valid=1 and in_x=0xDEAD -> out_valid stays 1, IX/IY/out_count unchanged, in_ready=0. 0xDEAD is accepted as element 0 only after the out handshake.
5. Stale-slot clear: full vector x=9,9,9,9, then a 1-element vector x=5 with in_last -> IX=0x00000000_00000000_00000000_00000005, out_count=1.
6. Gapped input: in_valid toggling 1,0,0,1,1,0,1 with x=1..4 -> same IX as scenario 2; out_valid one cycle after the 4th accepted element.

Source files
------------

// File: rtl/vector_pair_loader.sv
// Packs (x, y) element pairs into SIZE-bit operand buses; out_valid rises one cycle after the closing accept.
// in_ready is low for the whole HOLD phase, so the completed pair stays bit-stable until out_ready.
module vector_pair_loader #(
    parameter int  SIZE_ARRAY = 4,
    parameter int  SIZE_INT   = 32,
    localparam int SIZE       = SIZE_ARRAY * SIZE_INT,
    localparam int CW         = $clog2(SIZE_ARRAY + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SIZE_INT-1:0] in_x,
    input  logic [SIZE_INT-1:0] in_y,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SIZE-1:0]     IX,
    output logic [SIZE-1:0]     IY,
    output logic [CW-1:0]       out_count
);

    localparam int IW = (SIZE_ARRAY > 1) ? $clog2(SIZE_ARRAY) : 1;

    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [IW-1:0]       r_idx;
    logic [SIZE_INT-1:0] r_x [SIZE_ARRAY];
    logic [SIZE_INT-1:0] r_y [SIZE_ARRAY];
    logic [CW-1:0]       r_count;
    logic                w_accept;
    logic                w_close;
    logic                w_out_hs;

    assign w_accept = in_valid && (r_state == FILL);
    assign w_close  = w_accept && (in_last || (r_idx == IW'(SIZE_ARRAY - 1)));
    assign w_out_hs = (r_state == HOLD) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            FILL:    if (w_close)  w_next = HOLD;
            HOLD:    if (w_out_hs) w_next = FILL;
            default: w_next = FILL;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == FILL);
        out_valid = (r_state == HOLD);
    end

    // Closing accept also clears every slot above the write index so stale data reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_count <= '0;
            for (int k = 0; k < SIZE_ARRAY; k++) begin
                r_x[k] <= '0;
                r_y[k] <= '0;
            end
        end else if (w_accept) begin
            for (int k = 0; k < SIZE_ARRAY; k++) begin
                if (IW'(k) == r_idx) begin
                    r_x[k] <= in_x;
                    r_y[k] <= in_y;
                end else if (w_close && (IW'(k) > r_idx)) begin
                    r_x[k] <= '0;
                    r_y[k] <= '0;
                end
            end
            if (w_close) begin
                r_count <= CW'(r_idx) + CW'(1);
            end else begin
                r_idx <= r_idx + IW'(1);
            end
        end else if (w_out_hs) begin
            r_idx <= '0;
        end
    end

    for (genvar g = 0; g < SIZE_ARRAY; g++) begin : g_pack
        assign IX[g*SIZE_INT +: SIZE_INT] = r_x[g];
        assign IY[g*SIZE_INT +: SIZE_INT] = r_y[g];
    end

    assign out_count = r_count;

endmodule

// File: tb/tb_vector_pair_loader.sv
// Directed scenarios plus random traffic against a queue-based reference model of the loader.
`timescale 1ns/1ps
module tb_vector_pair_loader;
    localparam int SA = 4;
    localparam int SI = 32;
    localparam int SZ = SA * SI;
    localparam int CW = $clog2(SA + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b0;
    logic [SI-1:0] in_x = '0;
    logic [SI-1:0] in_y = '0;
    logic          in_ready;
    logic          out_valid;
    logic [SZ-1:0] IX;
    logic [SZ-1:0] IY;
    logic [CW-1:0] out_count;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: pending elements of the vector being built, and the last closed vector.
    logic [SI-1:0] q_x[$];
    logic [SI-1:0] q_y[$];
    logic          m_hold = 1'b0;
    logic [SZ-1:0] m_ix = '0;
    logic [SZ-1:0] m_iy = '0;
    int            m_cnt = 0;
    int            acc_cyc[$];

    vector_pair_loader dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .IX(IX), .IY(IY), .out_count(out_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [SZ-1:0] obs, input logic [SZ-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] dot(input logic [SZ-1:0] a, input logic [SZ-1:0] b);
        logic [63:0] s;
        s = '0;
        for (int k = 0; k < SA; k++) s += 64'(a[k*SI +: SI]) * 64'(b[k*SI +: SI]);
        return s;
    endfunction

    // Drive one cycle of stimulus, advance the model across the edge, then compare.
    task automatic tick(input logic v, input logic [SI-1:0] x, input logic [SI-1:0] y,
                        input logic last, input logic ordy);
        bit acc;
        bit hs;
        in_valid = v; in_x = x; in_y = y; in_last = last; out_ready = ordy;
        acc = v && !m_hold;
        hs  = m_hold && ordy;
        if (in_valid && in_ready) acc_cyc.push_back(cyc);
        @(posedge clk); #1;
        if (hs) m_hold = 1'b0;
        if (acc) begin
            q_x.push_back(x);
            q_y.push_back(y);
            if (last || q_x.size() == SA) begin
                m_ix = '0;
                m_iy = '0;
                foreach (q_x[i]) begin
                    m_ix[i*SI +: SI] = q_x[i];
                    m_iy[i*SI +: SI] = q_y[i];
                end
                m_cnt  = q_x.size();
                m_hold = 1'b1;
                q_x.delete();
                q_y.delete();
            end
        end
        chk("out_valid", out_valid, m_hold);
        chk("in_ready", in_ready, !m_hold);
        chk("out_count", out_count, m_cnt);
        if (m_hold) begin
            chk("IX", IX, m_ix);
            chk("IY", IY, m_iy);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        q_x.delete();
        q_y.delete();
        m_hold = 1'b0;
        m_cnt  = 0;
        chk("rst_IX", IX, '0);
        chk("rst_IY", IY, '0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_count", out_count, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [SZ-1:0] e_ix;
        logic [SZ-1:0] e_iy;

        #1;
        do_reset();

        // Reset mid-fill discards the partial vector.
        tick(1, 7, 70, 0, 1);
        tick(1, 8, 80, 0, 1);
        do_reset();
        for (int i = 0; i < SA; i++) tick(1, 11 + i, 21 + i, 0, 0);
        e_ix = 128'h0000000e_0000000d_0000000c_0000000b;
        chk("fresh_after_reset_IX", IX, e_ix);
        tick(0, 0, 0, 0, 1);

        // Full vector, single-cycle valid and SIZE_ARRAY+1 cycle throughput.
        acc_cyc.delete();
        for (int i = 0; i < SA; i++) tick(1, 1 + i, 5 + i, 0, 1);
        e_ix = 128'h00000004_00000003_00000002_00000001;
        e_iy = 128'h00000008_00000007_00000006_00000005;
        chk("full_IX", IX, e_ix);
        chk("full_IY", IY, e_iy);
        chk("full_count", out_count, 4);
        chk("full_dot", dot(IX, IY), 70);
        tick(1, 100, 200, 0, 1);
        chk("valid_one_cycle", out_valid, 1'b0);
        tick(1, 100, 200, 0, 1);
        chk("throughput", acc_cyc[4] - acc_cyc[0], 5);
        for (int i = 1; i < SA; i++) tick(1, 100 + i, 200 + i, 0, 1);
        tick(0, 0, 0, 0, 1);

        // Short vector with in_last.
        tick(1, 3, 10, 0, 1);
        tick(1, 4, 20, 1, 1);
        chk("short_IX_hi", IX[127:64], '0);
        chk("short_IY_hi", IY[127:64], '0);
        chk("short_count", out_count, 2);
        chk("short_dot", dot(IX, IY), 110);
        tick(0, 0, 0, 0, 1);

        // Backpressure with in_valid held high.
        for (int i = 0; i < SA; i++) tick(1, $urandom, $urandom, 0, 0);
        repeat (5) tick(1, 32'hDEAD, 32'hBEEF, 0, 0);
        chk("bp_valid", out_valid, 1'b1);
        chk("bp_in_ready", in_ready, 1'b0);
        tick(1, 32'hDEAD, 32'hBEEF, 0, 1);
        tick(1, 32'hDEAD, 32'hBEEF, 0, 1);
        for (int i = 1; i < SA; i++) tick(1, i, i, 0, 1);
        chk("bp_dead_elem0", IX[31:0], 32'hDEAD);
        tick(0, 0, 0, 0, 1);

        // Stale slots cleared by a short vector.
        for (int i = 0; i < SA; i++) tick(1, 9, 9, 0, 0);
        tick(0, 0, 0, 0, 1);
        tick(1, 5, 6, 1, 1);
        e_ix = 128'h00000000_00000000_00000000_00000005;
        chk("stale_IX", IX, e_ix);
        chk("stale_count", out_count, 1);
        tick(0, 0, 0, 0, 1);

        // Gapped input; x/in_last on idle cycles must be ignored.
        tick(1, 1, 5, 0, 1);
        tick(0, 32'hBAD, 32'hBAD, 1, 1);
        tick(0, 32'hBAD, 32'hBAD, 1, 1);
        tick(1, 2, 6, 0, 1);
        tick(1, 3, 7, 0, 1);
        tick(0, 32'hBAD, 32'hBAD, 1, 1);
        tick(1, 4, 8, 0, 1);
        e_ix = 128'h00000004_00000003_00000002_00000001;
        chk("gapped_IX", IX, e_ix);
        chk("gapped_valid", out_valid, 1'b1);
        tick(0, 0, 0, 0, 1);

        // Random traffic.
        repeat (400) tick($urandom_range(0, 3) != 0, $urandom, $urandom,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
